// File: rtl/pow_target_sequencer.sv
// Byte-serial proof-of-work target check.
// Hash and target bytes arrive MSB-first. The first byte pair that differs
// decides whether the hash is strictly below the target. One result per
// digest is returned over a valid/ready handshake.

// Combinational 8-bit magnitude comparator (a = hash byte, b = target byte).
module eight_bit_comp (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic       equal,
    output logic       b_greater
);

    assign equal     = (a == b);
    assign b_greater = (b > a);

endmodule

module pow_target_sequencer #(
    parameter int NBYTES = 32,
    parameter int IDXW   = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [7:0]      in_hash,
    input  logic [7:0]      in_target,
    input  logic            in_last,
    output logic            res_valid,
    input  logic            res_ready,
    output logic            res_meets,
    output logic            res_equal,
    output logic            res_len_err,
    output logic [IDXW-1:0] res_idx,
    output logic            busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Byte counts in the wider counter domain; saturating one past a full
    // digest keeps over-long digests flagged as length errors.
    localparam logic [IDXW:0]   CNT_LIM = (IDXW+1)'(NBYTES);
    localparam logic [IDXW:0]   CNT_SAT = (IDXW+1)'(NBYTES + 1);
    localparam logic [IDXW+1:0] LEN_OK  = (IDXW+2)'(NBYTES);
    localparam logic [IDXW+1:0] ONE_W   = (IDXW+2)'(1);

    state_t          state;
    logic [IDXW:0]   cnt;
    logic            decided;
    logic            meets;
    logic [IDXW-1:0] idx;

    logic            cmp_equal;
    logic            cmp_b_greater;
    logic            xfer;
    logic            take_decision;
    logic [IDXW+1:0] cnt_inc;
    logic [IDXW:0]   cnt_next;
    logic            decided_n;
    logic            meets_n;
    logic [IDXW-1:0] idx_n;
    logic            len_err_n;

    eight_bit_comp u_comp (
        .a         (in_hash),
        .b         (in_target),
        .equal     (cmp_equal),
        .b_greater (cmp_b_greater)
    );

    assign in_ready = (state != HOLD);
    assign xfer     = in_valid & in_ready;

    // Only the first differing byte inside the nominal digest length counts.
    assign take_decision = xfer & ~decided & ~cmp_equal & (cnt < CNT_LIM);

    assign cnt_inc   = {1'b0, cnt} + ONE_W;
    assign cnt_next  = (cnt == CNT_SAT) ? cnt : cnt_inc[IDXW:0];
    assign decided_n = decided | take_decision;
    assign meets_n   = take_decision ? cmp_b_greater : meets;
    assign idx_n     = take_decision ? cnt[IDXW-1:0] : idx;
    assign len_err_n = (cnt_inc != LEN_OK);

    // Sequencer state, per-digest bookkeeping and registered result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            decided     <= 1'b0;
            meets       <= 1'b0;
            idx         <= '0;
            res_valid   <= 1'b0;
            res_meets   <= 1'b0;
            res_equal   <= 1'b0;
            res_len_err <= 1'b0;
            res_idx     <= '0;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE, RUN: begin
                    if (xfer) begin
                        cnt     <= cnt_next;
                        decided <= decided_n;
                        meets   <= meets_n;
                        idx     <= idx_n;
                        busy    <= 1'b1;
                        if (in_last) begin
                            state       <= HOLD;
                            res_valid   <= 1'b1;
                            res_len_err <= len_err_n;
                            res_meets   <= meets_n & ~len_err_n;
                            res_equal   <= ~decided_n & ~len_err_n;
                            res_idx     <= decided_n ? idx_n : '0;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                HOLD: begin
                    if (res_ready) begin
                        state       <= IDLE;
                        cnt         <= '0;
                        decided     <= 1'b0;
                        meets       <= 1'b0;
                        idx         <= '0;
                        res_valid   <= 1'b0;
                        res_meets   <= 1'b0;
                        res_equal   <= 1'b0;
                        res_len_err <= 1'b0;
                        res_idx     <= '0;
                        busy        <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pow_target_sequencer.sv
// Self-checking bench for pow_target_sequencer: directed digests with
// hand-computed results plus a digest-level reference model checked on
// every falling clock edge.
`timescale 1ns/1ps

module tb_pow_target_sequencer;

    localparam int NBYTES = 32;
    localparam int IDXW   = 5;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [7:0]      in_hash;
    logic [7:0]      in_target;
    logic            in_last;
    logic            res_valid;
    logic            res_ready;
    logic            res_meets;
    logic            res_equal;
    logic            res_len_err;
    logic [IDXW-1:0] res_idx;
    logic            busy;

    int n_checks;
    int n_errors;

    logic [7:0] vh [64];
    logic [7:0] vt [64];

    // Reference model state: bytes of the digest in flight and the result held.
    logic [7:0] mq_h [$];
    logic [7:0] mq_t [$];
    bit         m_hold;
    bit         m_meets;
    bit         m_equal;
    bit         m_err;
    int         m_idx;

    pow_target_sequencer #(.NBYTES(NBYTES), .IDXW(IDXW)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_hash     (in_hash),
        .in_target   (in_target),
        .in_last     (in_last),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_meets   (res_meets),
        .res_equal   (res_equal),
        .res_len_err (res_len_err),
        .res_idx     (res_idx),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Whole-digest evaluation straight from the comparison rules.
    task automatic modelResult();
        int  len;
        bit  found;
        int  first;
        len   = mq_h.size();
        found = 0;
        first = 0;
        for (int i = 0; i < len && i < NBYTES; i++) begin
            if (!found && mq_h[i] != mq_t[i]) begin
                found = 1;
                first = i;
            end
        end
        m_err   = (len != NBYTES);
        m_meets = found && (mq_h[first] < mq_t[first]) && !m_err;
        m_equal = !found && !m_err;
        m_idx   = found ? first : 0;
    endtask

    // Model update on each rising edge, cleared by reset.
    initial begin
        m_hold = 0;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                mq_h.delete();
                mq_t.delete();
                m_hold = 0;
            end else if (m_hold) begin
                if (res_ready) m_hold = 0;
            end else if (in_valid) begin
                mq_h.push_back(in_hash);
                mq_t.push_back(in_target);
                if (in_last) begin
                    modelResult();
                    m_hold = 1;
                    mq_h.delete();
                    mq_t.delete();
                end
            end
        end
    end

    // Every-cycle comparison of DUT outputs against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("res_valid", int'(res_valid), int'(m_hold));
                check("in_ready", int'(in_ready), int'(!m_hold));
                check("busy", int'(busy), int'(m_hold || mq_h.size() > 0));
                if (m_hold) begin
                    check("model_meets", int'(res_meets), int'(m_meets));
                    check("model_equal", int'(res_equal), int'(m_equal));
                    check("model_len_err", int'(res_len_err), int'(m_err));
                    check("model_idx", int'(res_idx), m_idx);
                end
            end
        end
    end

    task automatic fill(input int n, input logic [7:0] h, input logic [7:0] t);
        for (int i = 0; i < n; i++) begin
            vh[i] = h;
            vt[i] = t;
        end
    endtask

    // Drive one digest of n byte pairs; starts and ends just after a rising edge.
    task automatic applyStimulus(input int n, input bit gaps, input bit with_last);
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    in_valid  = 1'b0;
                    in_hash   = 8'($urandom);
                    in_target = 8'($urandom);
                    in_last   = 1'b1;
                    @(posedge clk); #1;
                end
            end
            in_valid  = 1'b1;
            in_hash   = vh[i];
            in_target = vt[i];
            in_last   = with_last && (i == n - 1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Hand-computed result check, then hold for hold_cycles and hand the result off.
    task automatic checkOutput(input string tag, input int meets, input int equal,
                               input int err, input int idx, input int hold_cycles);
        @(negedge clk);
        check({tag, "_valid"}, int'(res_valid), 1);
        check({tag, "_meets"}, int'(res_meets), meets);
        check({tag, "_equal"}, int'(res_equal), equal);
        check({tag, "_len_err"}, int'(res_len_err), err);
        check({tag, "_idx"}, int'(res_idx), idx);
        repeat (hold_cycles) begin
            in_valid  = 1'b1;
            in_hash   = 8'($urandom);
            in_target = 8'($urandom);
            in_last   = 1'b1;
            @(posedge clk); #1;
            check({tag, "_hold_ready"}, int'(in_ready), 0);
            check({tag, "_hold_idx"}, int'(res_idx), idx);
            check({tag, "_hold_meets"}, int'(res_meets), meets);
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        check({tag, "_after_valid"}, int'(res_valid), 0);
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_hash   = 8'h00;
        in_target = 8'h00;
        in_last   = 1'b0;
        res_ready = 1'b0;

        #2;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_res_valid", int'(res_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_res_idx", int'(res_idx), 0);
        check("rst_res_equal", int'(res_equal), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // All bytes equal.
        fill(32, 8'hA5, 8'hA5);
        applyStimulus(32, 0, 1);
        checkOutput("t1_equal", 0, 1, 0, 0, 0);

        // Decision on byte 0, later bytes ignored.
        fill(32, 8'hFF, 8'h00);
        vh[0] = 8'h00; vt[0] = 8'h01;
        applyStimulus(32, 0, 1);
        checkOutput("t2_byte0", 1, 0, 0, 0, 0);

        // Decision on byte 5 with hash above target.
        for (int i = 0; i < 32; i++) begin
            vh[i] = 8'($urandom);
            vt[i] = 8'($urandom);
        end
        for (int i = 0; i < 5; i++) vt[i] = vh[i];
        vh[5] = 8'h80; vt[5] = 8'h7F;
        applyStimulus(32, 0, 1);
        checkOutput("t3_byte5", 0, 0, 0, 5, 0);

        // Short (31) and long (33) digests, first difference at byte 2.
        fill(40, 8'h11, 8'h11);
        vh[2] = 8'h10; vt[2] = 8'h20;
        applyStimulus(31, 0, 1);
        checkOutput("t4_short", 0, 0, 1, 2, 0);
        applyStimulus(33, 0, 1);
        checkOutput("t4_long", 0, 0, 1, 2, 0);

        // Single-byte digest.
        fill(1, 8'h42, 8'h42);
        applyStimulus(1, 0, 1);
        checkOutput("t4_one", 0, 0, 1, 0, 0);

        // Decision on the final byte.
        fill(32, 8'h5A, 8'h5A);
        vh[31] = 8'h10; vt[31] = 8'h20;
        applyStimulus(32, 0, 1);
        checkOutput("t4_lastbyte", 1, 0, 0, 31, 0);

        // Only the 33rd byte differs: beyond the digest, never decides.
        fill(33, 8'h77, 8'h77);
        vh[32] = 8'h01; vt[32] = 8'h02;
        applyStimulus(33, 0, 1);
        checkOutput("t4_byte32", 0, 0, 1, 0, 0);

        // Gapped input, result held 10 cycles, then the next digest.
        fill(32, 8'h3C, 8'h3C);
        vh[7] = 8'h40; vt[7] = 8'h41;
        vh[20] = 8'hFF; vt[20] = 8'h00;
        applyStimulus(32, 1, 1);
        checkOutput("t5_hold", 1, 0, 0, 7, 10);
        fill(32, 8'hC3, 8'hC3);
        applyStimulus(32, 1, 1);
        checkOutput("t5_next", 0, 1, 0, 0, 0);

        // Asynchronous reset after byte 10 of a decided digest.
        fill(32, 8'h99, 8'h99);
        vh[2] = 8'h10; vt[2] = 8'h90;
        applyStimulus(11, 0, 0);
        #2;
        check("t6_pre_busy", int'(busy), 1);
        rst = 1'b1;
        #1;
        check("t6_busy", int'(busy), 0);
        check("t6_in_ready", int'(in_ready), 1);
        check("t6_res_valid", int'(res_valid), 0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        fill(32, 8'h99, 8'h99);
        applyStimulus(32, 0, 1);
        checkOutput("t6_fresh", 0, 1, 0, 0, 0);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
